demux1_n_buf: RTL and testbench

Parametrised, registered 1-to-N demultiplexer. Each output channel has a one-entry holding register and a valid/ready handshake, and the block also offers a broadcast mode and a drop counter for out-of-range selects. It extends the combinational 16-bit 1-to-16 demux tree into a pipelined, back-pressure-aware router. It sits between a single producer (a register-file write port or the ALU result bus) and N independent consumers.

---
 rtl/demux1_n_buf.sv | 83 ++++++++
 tb/tb_demux1_n_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1_n_buf.sv
// Registered 1-to-N demux, one holding register per channel; data visible 1 cycle after accept.
// in_ready drops when the addressed channel (or any channel, for broadcast) is full and not draining.
module demux1_n_buf #(
   parameter int WIDTH = 16,
   parameter int N     = 16,
   parameter int SEL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   Y,
   input  logic [SEL_W-1:0]   Sel,
   input  logic               bcast,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [N*WIDTH-1:0] x,
   output logic [N-1:0]       x_valid,
   input  logic [N-1:0]       x_ready,
   output logic [7:0]         drop_count
);

   // One extra bit so N == 2**SEL_W is representable.
   localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

   logic [N-1:0]            v;
   logic [N-1:0][WIDTH-1:0] d;
   logic [N-1:0]            sel_hit;
   logic [N-1:0]            free;
   logic [N-1:0]            wr;
   logic                    sel_ok;
   logic                    accept;
   logic                    drop;
   logic [7:0]              drop_cnt;

   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < N; i++) begin
         sel_hit[i] = (Sel == SEL_W'(i));
      end
      sel_ok = ({1'b0, Sel} < N_L);
      free   = ~v | x_ready;

      if (bcast) begin
         in_ready = &free;
      end else if (sel_ok) begin
         in_ready = |(free & sel_hit);
      end else begin
         in_ready = 1'b1;
      end

      accept = in_valid & in_ready;
      wr     = '0;
      if (accept) begin
         wr = bcast ? {N{1'b1}} : sel_hit;
      end
      drop = accept & ~bcast & ~sel_ok;
   end

   // A write wins over a drain on the same channel, so a draining slot refills without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         v        <= '0;
         d        <= '0;
         drop_cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (wr[i]) begin
               d[i] <= Y;
               v[i] <= 1'b1;
            end else if (x_ready[i]) begin
               v[i] <= 1'b0;
            end
         end
         if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   assign x          = d;
   assign x_valid    = v;
   assign drop_count = drop_cnt;

endmodule

// File: tb/tb_demux1_n_buf.sv
// Bench for demux1_n_buf: a 16-channel instance with a queue scoreboard and a 12-channel one for drops.
module tb_demux1_n_buf;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   Y;
   logic [3:0]    Sel;
   logic          bcast;
   logic          in_valid;
   logic          in_ready;
   logic [255:0]  x;
   logic [15:0]   x_valid;
   logic [15:0]   x_ready;
   logic [7:0]    drop_count;

   logic          iv12;
   logic          in_ready12;
   logic [191:0]  x12;
   logic [11:0]   x_valid12;
   logic [11:0]   x_ready12;
   logic [7:0]    drop_count12;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;
   logic [15:0] exp_q [16][$];

   always #5 clk = ~clk;

   demux1_n_buf #(.WIDTH(16), .N(16), .SEL_W(4)) dut (
      .clk(clk), .rst(rst), .Y(Y), .Sel(Sel), .bcast(bcast),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .x_valid(x_valid),
      .x_ready(x_ready), .drop_count(drop_count)
   );

   demux1_n_buf #(.WIDTH(16), .N(12), .SEL_W(4)) dut12 (
      .clk(clk), .rst(rst), .Y(Y), .Sel(Sel), .bcast(bcast),
      .in_valid(iv12), .in_ready(in_ready12), .x(x12), .x_valid(x_valid12),
      .x_ready(x_ready12), .drop_count(drop_count12)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] s, input logic [15:0] y, input logic bc);
      Sel      = s;
      Y        = y;
      bcast    = bc;
      in_valid = 1'b1;
   endtask

   // One clock: sample in_ready mid-cycle, cross the edge, record the expected result of any transfer.
   task automatic step(output logic acc);
      logic r;
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      acc = in_valid & r & ~rst;
      if (acc) begin
         if (bcast) begin
            for (int i = 0; i < 16; i++) exp_q[i].push_back(Y);
         end else begin
            exp_q[Sel].push_back(Y);
         end
      end
   endtask

   // Monitor: every held word must match the head of its channel queue; pop on consumption.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int i = 0; i < 16; i++) begin
               if (x_valid[i]) begin
                  if (exp_q[i].size() == 0) begin
                     chk($sformatf("spurious_valid_ch%0d", i), 64'(x_valid[i]), 64'd0);
                  end else begin
                     chk($sformatf("data_ch%0d", i), 64'(x[i*16 +: 16]), 64'(exp_q[i][0]));
                     if (x_ready[i]) void'(exp_q[i].pop_front());
                  end
               end else if (exp_q[i].size() != 0) begin
                  chk($sformatf("missing_valid_ch%0d", i), 64'(x_valid[i]), 64'd1);
               end
            end
         end
      end
   end

   initial begin
      logic acc;
      logic [7:0] exp_drop;

      rst       = 1'b1;
      Y         = 16'hAAAA;
      Sel       = 4'd3;
      bcast     = 1'b0;
      in_valid  = 1'b1;
      iv12      = 1'b0;
      x_ready   = 16'hFFFF;
      x_ready12 = 12'hFFF;

      // Reset held for two edges with a live request.
      step(acc);
      step(acc);
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("reset_x_valid", 64'(x_valid), 64'd0);
      chk("reset_x", 64'(x[63:0] | x[127:64] | x[191:128] | x[255:192]), 64'd0);
      chk("reset_drop", 64'(drop_count), 64'd0);
      chk("reset_x_valid12", 64'(x_valid12), 64'd0);
      chk("reset_drop12", 64'(drop_count12), 64'd0);
      mon_en = 1'b1;

      // Unicast stream to every channel, consumers always ready.
      for (int s = 0; s < 16; s++) begin
         drive(4'(s), 16'h1000 + 16'(s), 1'b0);
         step(acc);
         chk($sformatf("stream_accept_%0d", s), 64'(acc), 64'd1);
      end
      in_valid = 1'b0;
      step(acc);
      step(acc);
      chk("stream_drained", 64'(x_valid), 64'd0);

      // Back-pressure on channel 5 plus independence of channel 6.
      x_ready[5] = 1'b0;
      drive(4'd5, 16'h0055, 1'b0);
      step(acc);
      chk("bp_first_accept", 64'(acc), 64'd1);
      drive(4'd6, 16'h0066, 1'b0);
      step(acc);
      chk("indep_accept", 64'(acc), 64'd1);
      chk("indep_valid6", 64'(x_valid[6]), 64'd1);
      drive(4'd5, 16'h0056, 1'b0);
      step(acc);
      chk("bp_second_blocked", 64'(acc), 64'd0);
      step(acc);
      chk("bp_still_blocked", 64'(acc), 64'd0);
      chk("bp_hold_data", 64'(x[5*16 +: 16]), 64'h0055);
      x_ready[5] = 1'b1;
      step(acc);
      chk("bp_refill_accept", 64'(acc), 64'd1);
      chk("bp_valid_stays", 64'(x_valid[5]), 64'd1);
      chk("bp_new_data", 64'(x[5*16 +: 16]), 64'h0056);
      in_valid = 1'b0;
      step(acc);
      step(acc);
      chk("bp_drained", 64'(x_valid), 64'd0);

      // Broadcast blocked by one full, stalled channel.
      x_ready[2] = 1'b0;
      drive(4'd2, 16'h0022, 1'b0);
      step(acc);
      chk("bc_fill2", 64'(acc), 64'd1);
      drive(4'd9, 16'hBEEF, 1'b1);
      step(acc);
      chk("bc_blocked", 64'(acc), 64'd0);
      x_ready[2] = 1'b1;
      step(acc);
      chk("bc_accept", 64'(acc), 64'd1);
      chk("bc_all_valid", 64'(x_valid), 64'hFFFF);
      chk("bc_data_lo", 64'(x[63:0]), 64'hBEEF_BEEF_BEEF_BEEF);
      chk("bc_data_hi", 64'(x[255:192]), 64'hBEEF_BEEF_BEEF_BEEF);
      in_valid = 1'b0;
      bcast    = 1'b0;
      step(acc);
      step(acc);
      chk("bc_drained", 64'(x_valid), 64'd0);

      // Out-of-range selects on the 12-channel instance.
      exp_drop = 8'd0;
      Sel  = 4'd13;
      Y    = 16'h1313;
      iv12 = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         chk("drop_in_ready", 64'(in_ready12), 64'd1);
         chk("drop_no_valid", 64'(x_valid12), 64'd0);
         @(posedge clk);
         #1;
         if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
         chk($sformatf("drop_count_%0d", k), 64'(drop_count12), 64'(exp_drop));
      end
      iv12 = 1'b0;
      step(acc);
      chk("drop_saturated", 64'(drop_count12), 64'd255);
      chk("no_drop_16", 64'(drop_count), 64'd0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("queue_empty_%0d", i), 64'(exp_q[i].size()), 64'd0);
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
